// File: rtl/ram_stream_reader_if.sv
// Valid/ready stream carrying RAM words from ram_stream_reader to its consumer.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range and presents the words as a
// valid/ready stream. A 2-entry buffer absorbs the one-cycle RAM read
// latency and downstream backpressure; reads are only issued when the
// buffer is guaranteed to have room for the returning word.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  ram_stream_reader_if.master   strm
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH:0]   remaining;

  // Read issued at the previous edge; its word is on rdata this cycle.
  logic                  rd_vld_p1;
  logic                  rd_last_p1;

  // Two-entry buffer, entry 0 is the head presented on the stream.
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] buf0_data;
  logic [DATA_WIDTH-1:0] buf1_data;
  logic                  buf0_last;
  logic                  buf1_last;

  logic                  cmd_accept;
  logic                  cmd_empty;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  done_nxt;

  assign strm.m_valid = (count != 2'd0);
  assign strm.m_data  = buf0_data;
  assign strm.m_last  = buf0_last;
  assign pop          = strm.m_valid & strm.m_ready;
  assign push         = rd_vld_p1;
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave RUN once the final read issues, leave DRAIN on the final beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_accept) state_nxt = RUN;
      RUN:     if (issue && (remaining == LEN_ONE)) state_nxt = DRAIN;
      DRAIN:   if (done_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode: reads issue only if occupancy after this edge stays below 2.
  always_comb begin
    cmd_accept = 1'b0;
    cmd_empty  = 1'b0;
    issue      = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cmd_accept = start && (len != LEN_ZERO);
        cmd_empty  = start && (len == LEN_ZERO);
        done_nxt   = cmd_empty;
      end
      RUN: begin
        issue = (remaining != LEN_ZERO) &&
                (({1'b0, count} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop}));
      end
      DRAIN: begin
        done_nxt = pop && buf0_last;
      end
      default: ;
    endcase
  end

  // Address walk, word countdown, in-flight read tracking and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr      <= '0;
      remaining  <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= done_nxt;
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && (remaining == LEN_ONE);
      if (cmd_accept) begin
        raddr     <= base_addr;
        remaining <= len;
      end else if (issue) begin
        raddr     <= raddr + ADDR_ONE;
        remaining <= remaining - LEN_ONE;
      end
    end
  end

  // Buffer: capture returning words, shift the head out on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      buf0_data <= '0;
      buf1_data <= '0;
      buf0_last <= 1'b0;
      buf1_last <= 1'b0;
    end else begin
      assert (!(push && !pop && (count == 2'd2)))
        else $error("ram_stream_reader buffer overflow");
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            buf0_data <= rdata;
            buf0_last <= rd_last_p1;
          end else begin
            buf1_data <= rdata;
            buf1_last <= rd_last_p1;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_last <= buf1_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf0_data <= rdata;
            buf0_last <= rd_last_p1;
          end else begin
            buf0_data <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= rdata;
            buf1_last <= rd_last_p1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a registered-read RAM model, directed and
// randomized commands, and a queue of expected beats built from the RAM
// contents, the command base address and length.
module tb_ram_stream_reader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  ram_stream_reader_if #(.DATA_WIDTH(DW)) strm ();

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) rdata <= mem[raddr];

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            exp_busy = 1'b0;
  bit            exp_done = 1'b0;
  bit            chk_raddr = 1'b0;
  logic [AW-1:0] exp_raddr = '0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            cyc = 0;
  int            first_valid_cyc = -1;
  int            first_hs_cyc = -1;
  int            last_hs_cyc = -1;
  int            pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic tick(input bit r, input bit st, input logic [AW-1:0] b,
                      input logic [AW:0] l, input bit rdy);
    bit            hs;
    bit            nb;
    bit            nd;
    bit            nr;
    bit            accept;
    beat_t         e;
    logic [AW-1:0] a;
    rst = r;
    start = st;
    base_addr = b;
    len = l;
    strm.m_ready = rdy;
    #1;
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (chk_raddr) chk("raddr_load", {24'd0, raddr}, {24'd0, exp_raddr});
    if (strm.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall) begin
      chk("stall_valid", {31'd0, strm.m_valid}, 32'd1);
      chk("stall_data", {24'd0, strm.m_data}, {24'd0, prev_data});
      chk("stall_last", {31'd0, strm.m_last}, {31'd0, prev_last});
    end
    if (exp_q.size() == 0) chk("valid_without_beat", {31'd0, strm.m_valid}, 32'd0);
    hs = strm.m_valid && strm.m_ready && !r && (exp_q.size() != 0);
    nb = exp_busy;
    nd = 1'b0;
    nr = 1'b0;
    if (hs) begin
      e = exp_q.pop_front();
      chk("beat_data", {24'd0, strm.m_data}, {24'd0, e.data});
      chk("beat_last", {31'd0, strm.m_last}, {31'd0, e.last});
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      if (e.last) begin
        nd = 1'b1;
        nb = 1'b0;
      end
    end
    accept = st && !exp_busy && !r;
    if (accept && l == 0) nd = 1'b1;
    if (accept && l != 0) begin
      nb = 1'b1;
      nr = 1'b1;
      for (int i = 0; i < int'(l); i++) begin
        a = b + AW'(i);
        exp_q.push_back({(i == int'(l) - 1), mem[a]});
      end
    end
    prev_stall = strm.m_valid && !strm.m_ready && !r;
    prev_data = strm.m_data;
    prev_last = strm.m_last;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (r) begin
      exp_q.delete();
      nb = 1'b0;
      nd = 1'b0;
      nr = 1'b0;
      prev_stall = 1'b0;
    end
    exp_busy = nb;
    exp_done = nd;
    chk_raddr = nr;
    exp_raddr = b;
  endtask

  // Idle cycles until the model has no outstanding command, then one more
  // cycle so the done pulse is checked. mode: 0 ready, 1 pattern, 2 random.
  task automatic run_until_idle(input int mode);
    int n;
    bit rdy;
    n = 0;
    while ((exp_q.size() != 0 || exp_busy) && n < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[n % 6][0];
        default: rdy = ($urandom_range(0, 99) < 65);
      endcase
      tick(0, 0, '0, '0, rdy);
      n++;
    end
    chk("drain_timeout", {31'd0, (n >= 2000)}, 32'd0);
    tick(0, 0, '0, '0, 1'b1);
  endtask

  initial begin
    int start_cyc;
    logic [AW-1:0] rb;
    logic [AW:0]   rl;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    strm.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_valid", {31'd0, strm.m_valid}, 32'd0);
    chk("reset_last", {31'd0, strm.m_last}, 32'd0);
    chk("reset_raddr", {24'd0, raddr}, 32'd0);
    chk("reset_data", {24'd0, strm.m_data}, 32'd0);

    // Basic command, sink always ready.
    start_cyc = cyc;
    first_valid_cyc = -1;
    first_hs_cyc = -1;
    tick(0, 1, 8'h04, 9'd4, 1'b1);
    run_until_idle(0);
    chk("first_valid_edges", 32'(first_valid_cyc - start_cyc), 32'd3);
    chk("beat_spacing", 32'(last_hs_cyc - first_hs_cyc), 32'd3);

    // Same command under a stalling sink.
    tick(0, 1, 8'h04, 9'd4, 1'b0);
    run_until_idle(1);

    // Address wrap at the top of the RAM.
    tick(0, 1, 8'hFE, 9'd4, 1'b1);
    run_until_idle(2);

    // Zero-length command.
    tick(0, 1, 8'h10, 9'd0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);

    // Reset in the middle of a run, then a fresh command.
    tick(0, 1, 8'h00, 9'd8, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    tick(1, 0, '0, '0, 1'b0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_valid", {31'd0, strm.m_valid}, 32'd0);
    chk("midrst_last", {31'd0, strm.m_last}, 32'd0);
    chk("midrst_raddr", {24'd0, raddr}, 32'd0);
    chk("midrst_data", {24'd0, strm.m_data}, 32'd0);
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 1, 8'h20, 9'd2, 1'b1);
    run_until_idle(0);

    // Start re-pulsed mid-run must be ignored.
    tick(0, 1, 8'h00, 9'd6, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 1, 8'h80, 9'd6, 1'b1);
    run_until_idle(1);

    // Randomized RAM contents and commands.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      rl = 9'($urandom_range(1, 24));
      tick(0, 1, rb, rl, ($urandom_range(0, 1) == 1));
      run_until_idle(2);
    end

    // Whole-RAM read with a random sink.
    tick(0, 1, 8'($urandom), 9'd256, 1'b1);
    run_until_idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
